// File: rtl/fft_ctrl_seq.sv
// FFT job sequencer: loads a block from the in FIFO, steps the butterfly
// stages, optionally runs a filter pass, then drains the result to the out FIFO.
module fft_ctrl_seq #(
  parameter int LOG2_N  = 10,
  parameter int SIG_W   = 18,
  parameter int DATA_W  = 512,
  parameter int POINT_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startF,
  input  logic               startI,
  input  logic               filter,
  input  logic [SIG_W-1:0]   sigNum,
  input  logic               inFifoReady,
  input  logic               loadExternalDone,
  input  logic               accelWrBlkDone,
  output logic               calculating,
  output logic               done,
  output logic [SIG_W-1:0]   sigNumMC,
  output logic               isIFFT,
  output logic               loadExternal,
  output logic               loadInternal,
  output logic               filterActive,
  output logic               writeOut,
  output logic [4:0]         stageCount,
  output logic [LOG2_N-2:0]  cycleCount,
  output logic               startErr,
  output logic [2:0]         stateDbg
);

  localparam int N     = 1 << LOG2_N;
  localparam int WORDS = N * POINT_W / DATA_W;
  localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [LOG2_N-2:0] CYC_LAST   = '1;
  localparam logic [4:0]        STAGE_LAST = 5'(LOG2_N - 1);
  localparam logic [4:0]        STAGE_FILT = 5'(LOG2_N);
  localparam logic [WC_W-1:0]   WORD_LAST  = WC_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IN  = 3'd1,
    LOAD_EXT = 3'd2,
    CALC     = 3'd3,
    FILTER   = 3'd4,
    UNLOAD   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t          state;
  logic            filterEn;
  logic [WC_W-1:0] wordCnt;

  assign stateDbg = state;

  // Handshake-free control: starts, loadExternalDone and accelWrBlkDone are
  // single-cycle events that only count in the state that expects them;
  // strobes are levels that hold for the whole phase they name.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      filterEn     <= 1'b0;
      wordCnt      <= '0;
      calculating  <= 1'b0;
      done         <= 1'b0;
      sigNumMC     <= '0;
      isIFFT       <= 1'b0;
      loadExternal <= 1'b0;
      loadInternal <= 1'b0;
      filterActive <= 1'b0;
      writeOut     <= 1'b0;
      stageCount   <= '0;
      cycleCount   <= '0;
      startErr     <= 1'b0;
    end else begin
      done     <= 1'b0;
      startErr <= 1'b0;
      if (state != IDLE && (startF || startI))
        startErr <= 1'b1;

      case (state)
        IDLE: begin
          if (startF && startI) begin
            startErr <= 1'b1;
          end else if (startF || startI) begin
            sigNumMC    <= sigNum;
            isIFFT      <= startI;
            filterEn    <= filter & startF;
            calculating <= 1'b1;
            state       <= WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (inFifoReady) begin
            loadExternal <= 1'b1;
            state        <= LOAD_EXT;
          end
        end
        LOAD_EXT: begin
          if (loadExternalDone) begin
            loadExternal <= 1'b0;
            loadInternal <= 1'b1;
            stageCount   <= '0;
            cycleCount   <= '0;
            state        <= CALC;
          end
        end
        CALC: begin
          // cycleCount wraps to 0 naturally at N/2-1
          cycleCount <= cycleCount + 1'b1;
          if (cycleCount == CYC_LAST) begin
            if (stageCount == STAGE_LAST) begin
              loadInternal <= 1'b0;
              if (filterEn) begin
                filterActive <= 1'b1;
                stageCount   <= STAGE_FILT;
                state        <= FILTER;
              end else begin
                writeOut <= 1'b1;
                state    <= UNLOAD;
              end
            end else begin
              stageCount <= stageCount + 5'd1;
            end
          end
        end
        FILTER: begin
          cycleCount <= cycleCount + 1'b1;
          if (cycleCount == CYC_LAST) begin
            filterActive <= 1'b0;
            writeOut     <= 1'b1;
            state        <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (accelWrBlkDone) begin
            if (wordCnt == WORD_LAST) begin
              wordCnt     <= '0;
              writeOut    <= 1'b0;
              calculating <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              wordCnt <= wordCnt + 1'b1;
            end
          end
        end
        DONE: begin
          filterEn <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ctrl_seq.sv
// Directed bench for fft_ctrl_seq: a default-size instance (N=1024) and a
// small instance (N=8) driven one after the other from a single sequence.
module tb_fft_ctrl_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance signals
  logic        dStartF, dStartI, dFilter, dInFifo, dLoadExtDone, dAcc;
  logic [17:0] dSigNum, dSigNumMC;
  logic        dCalc, dDone, dIsIFFT, dLoadExt, dLoadInt, dFiltAct, dWriteOut, dStartErr;
  logic [4:0]  dStage;
  logic [8:0]  dCycle;
  logic [2:0]  dState;

  // LOG2_N=3 instance signals
  logic        sStartF, sStartI, sFilter, sInFifo, sLoadExtDone, sAcc;
  logic [17:0] sSigNum, sSigNumMC;
  logic        sCalc, sDone, sIsIFFT, sLoadExt, sLoadInt, sFiltAct, sWriteOut, sStartErr;
  logic [4:0]  sStage;
  logic [1:0]  sCycle;
  logic [2:0]  sState;

  fft_ctrl_seq dut (
    .clk(clk), .rst(rst), .startF(dStartF), .startI(dStartI), .filter(dFilter),
    .sigNum(dSigNum), .inFifoReady(dInFifo), .loadExternalDone(dLoadExtDone),
    .accelWrBlkDone(dAcc), .calculating(dCalc), .done(dDone), .sigNumMC(dSigNumMC),
    .isIFFT(dIsIFFT), .loadExternal(dLoadExt), .loadInternal(dLoadInt),
    .filterActive(dFiltAct), .writeOut(dWriteOut), .stageCount(dStage),
    .cycleCount(dCycle), .startErr(dStartErr), .stateDbg(dState)
  );

  fft_ctrl_seq #(.LOG2_N(3)) dut3 (
    .clk(clk), .rst(rst), .startF(sStartF), .startI(sStartI), .filter(sFilter),
    .sigNum(sSigNum), .inFifoReady(sInFifo), .loadExternalDone(sLoadExtDone),
    .accelWrBlkDone(sAcc), .calculating(sCalc), .done(sDone), .sigNumMC(sSigNumMC),
    .isIFFT(sIsIFFT), .loadExternal(sLoadExt), .loadInternal(sLoadInt),
    .filterActive(sFiltAct), .writeOut(sWriteOut), .stageCount(sStage),
    .cycleCount(sCycle), .startErr(sStartErr), .stateDbg(sState)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int expStage, expCycle, bad, li, fa, badStage;

  initial begin
    rst = 1'b1;
    {dStartF, dStartI, dFilter, dInFifo, dLoadExtDone, dAcc} = '0;
    {sStartF, sStartI, sFilter, sInFifo, sLoadExtDone, sAcc} = '0;
    dSigNum = '0;
    sSigNum = '0;
    step();
    step();
    chk("rst_calc", {31'd0, dCalc}, 0);
    chk("rst_state", {29'd0, dState}, 0);
    chk("rst_counts", {23'd0, dStage, dCycle}, 0);
    chk("rst_small", {25'd0, sCalc, sLoadExt, sLoadInt, sWriteOut, sState}, 0);
    rst = 1'b0;
    step();

    // both starts together in IDLE
    dStartF = 1; dStartI = 1; dSigNum = 18'd44;
    step();
    dStartF = 0; dStartI = 0;
    chk("both_err", {31'd0, dStartErr}, 1);
    chk("both_calc", {31'd0, dCalc}, 0);
    chk("both_nocapture", {14'd0, dSigNumMC}, 0);
    step();
    chk("err_one_cycle", {31'd0, dStartErr}, 0);

    // inverse job aborted by reset at stage 4, cycle 200
    dStartI = 1; dSigNum = 18'd7;
    step();
    dStartI = 0;
    chk("abort_isifft", {31'd0, dIsIFFT}, 1);
    chk("abort_state", {29'd0, dState}, 1);
    dInFifo = 1;
    step();
    dInFifo = 0; dLoadExtDone = 1;
    step();
    dLoadExtDone = 0;
    repeat (4 * 512 + 200) step();
    chk("abort_pos", {23'd0, dStage, dCycle}, {23'd0, 5'd4, 9'd200});
    rst = 1;
    step();
    rst = 0;
    chk("abort_outs", {20'd0, dCalc, dIsIFFT, dLoadInt, dLoadExt, dWriteOut, dDone, dState}, 0);
    chk("abort_counts", {23'd0, dStage, dCycle}, 0);
    chk("abort_signum", {14'd0, dSigNumMC}, 0);

    // full forward job at default size
    dStartF = 1; dSigNum = 18'd1;
    step();
    dStartF = 0;
    chk("job_signum", {14'd0, dSigNumMC}, 1);
    chk("job_calc", {31'd0, dCalc}, 1);
    dInFifo = 1;
    step();
    dInFifo = 0;
    chk("job_loadext", {31'd0, dLoadExt}, 1);
    dAcc = 1;
    step();
    dAcc = 0;
    chk("stray_acc_hold", {28'd0, dLoadExt, dState}, {28'd0, 1'b1, 3'd2});
    dLoadExtDone = 1;
    step();
    dLoadExtDone = 0;
    chk("calc_entry", {29'd0, dLoadExt, dLoadInt, dWriteOut}, 3'b010);

    expStage = 0; expCycle = 0; bad = 0;
    for (int k = 0; k < 5120; k++) begin
      if (dLoadInt !== 1'b1 || dStage !== 5'(expStage) || dCycle !== 9'(expCycle)) bad++;
      if (k == 300) dStartF = 1;
      if (k == 1000) dLoadExtDone = 1;
      step();
      dStartF = 0; dLoadExtDone = 0;
      if (k == 300) chk("calc_start_err", {31'd0, dStartErr}, 1);
      expCycle++;
      if (expCycle == 512) begin
        expCycle = 0;
        expStage++;
      end
    end
    chk("calc_trace", bad, 0);
    chk("calc_exit", {29'd0, dLoadInt, dFiltAct, dWriteOut}, 3'b001);
    chk("calc_exit_state", {29'd0, dState}, 5);

    for (int w = 0; w < 128; w++) begin
      dAcc = 1;
      step();
      dAcc = 0;
      if (w == 126) chk("unload_127", {30'd0, dDone, dWriteOut}, 2'b01);
    end
    chk("done_pulse", {29'd0, dDone, dCalc, dWriteOut}, 3'b100);
    dStartI = 1;
    step();
    dStartI = 0;
    chk("done_start_err", {31'd0, dStartErr}, 1);
    chk("after_done", {29'd0, dDone, dCalc, dIsIFFT}, 0);
    chk("signum_hold", {14'd0, dSigNumMC}, 1);
    dStartF = 1; dSigNum = 18'd2;
    step();
    dStartF = 0;
    chk("idle_accept", {13'd0, dCalc, dSigNumMC}, {13'd0, 1'b1, 18'd2});

    // small instance: inverse with filter requested -> no filter pass
    sStartI = 1; sFilter = 1; sSigNum = 18'd3;
    step();
    sStartI = 0; sFilter = 0;
    chk("s_isifft", {31'd0, sIsIFFT}, 1);
    sInFifo = 1;
    step();
    sInFifo = 0; sLoadExtDone = 1;
    step();
    sLoadExtDone = 0;
    li = 0; fa = 0;
    for (int i = 0; i < 40; i++) begin
      if (sWriteOut) break;
      li += int'(sLoadInt);
      fa += int'(sFiltAct);
      step();
    end
    chk("s_inv_calc_len", li, 12);
    chk("s_inv_no_filter", fa, 0);
    chk("s_inv_unload", {31'd0, sWriteOut}, 1);
    sAcc = 1;
    step();
    sAcc = 0;
    chk("s_inv_done", {31'd0, sDone}, 1);
    step();

    // small instance: forward with filter
    sStartF = 1; sFilter = 1; sSigNum = 18'd5;
    step();
    sStartF = 0; sFilter = 0;
    chk("s_fwd_isifft", {31'd0, sIsIFFT}, 0);
    sInFifo = 1;
    step();
    sInFifo = 0; sLoadExtDone = 1;
    step();
    sLoadExtDone = 0;
    li = 0; fa = 0; badStage = 0;
    for (int i = 0; i < 40; i++) begin
      if (sWriteOut) break;
      li += int'(sLoadInt);
      if (sFiltAct) begin
        if (sStage !== 5'd3 || sCycle !== 2'(fa)) badStage++;
        fa++;
      end
      step();
    end
    chk("s_fwd_calc_len", li, 12);
    chk("s_fwd_filter_len", fa, 4);
    chk("s_fwd_filter_cnt", badStage, 0);
    chk("s_fwd_unload", {29'd0, sFiltAct, sState}, {29'd0, 1'b0, 3'd5});
    sAcc = 1;
    step();
    sAcc = 0;
    chk("s_fwd_done", {30'd0, sDone, sCalc}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
